// File: rtl/poliriscv_run_ctrl.sv
// Run/check controller for poliriscv_sc: holds the core in reset, lets it run
// until it halts or exhausts its cycle budget, then walks a list of register
// checks through the core's debug read port and reports the outcome.
//
// state   | meaning
// --------+------------------------------------------------------------------
// S_IDLE  | after reset; core held in reset, waiting for start
// S_RESET | core_rst asserted for RST_CYCLES cycles
// S_RUN   | core running; watch for halt or cycle budget exhaustion
// S_CHECK | one register compare per cycle through dbg_addr/dbg_data
// S_DONE  | result valid and held; core released so its state stays visible
module poliriscv_run_ctrl #(
   parameter int          XLEN        = 32,
   parameter int          NCHK        = 4,
   parameter int          RST_CYCLES  = 1,
   parameter int unsigned MAX_CYCLES  = 100,
   parameter int          HALT_REPEAT = 2
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        start,
   input  logic [NCHK*5-1:0]           chk_addr_flat,
   input  logic [NCHK*XLEN-1:0]        chk_exp_flat,
   input  logic [XLEN-1:0]             pc,
   input  logic [31:0]                 instruction,
   input  logic [XLEN-1:0]             dbg_data,
   output logic                        core_rst,
   output logic [4:0]                  dbg_addr,
   output logic                        busy,
   output logic                        done,
   output logic                        pass,
   output logic                        halted,
   output logic                        timeout,
   output logic [31:0]                 cycle_count,
   output logic [$clog2(NCHK+1)-1:0]   fail_idx
);

   localparam int FW  = $clog2(NCHK + 1);
   localparam int RCW = $clog2(RST_CYCLES + 1);
   localparam int RPW = $clog2(HALT_REPEAT + 1);

   localparam logic [FW-1:0]  NCHK_F    = FW'(NCHK);
   localparam logic [FW-1:0]  K_LAST    = FW'(NCHK - 1);
   localparam logic [RCW-1:0] RC_LOAD   = RCW'(RST_CYCLES - 1);
   localparam logic [RPW-1:0] RP_LOAD   = RPW'(HALT_REPEAT);
   localparam logic [RPW-1:0] RP_ONE    = RPW'(1);
   localparam logic [31:0]    MAX_C     = 32'(MAX_CYCLES);
   localparam logic [31:0]    HALT_INSN = 32'h0000_006F;

   typedef enum logic [2:0] {
      S_IDLE,
      S_RESET,
      S_RUN,
      S_CHECK,
      S_DONE
   } state_t;

   state_t            state_q, state_d;
   logic              core_rst_q, core_rst_d;
   logic [4:0]        dbg_addr_q, dbg_addr_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              pass_q, pass_d;
   logic              halted_q, halted_d;
   logic              timeout_q, timeout_d;
   logic [31:0]       cycle_count_q, cycle_count_d;
   logic [FW-1:0]     fail_idx_q, fail_idx_d;
   logic [RCW-1:0]    rst_cnt_q, rst_cnt_d;
   logic [RPW-1:0]    rep_left_q, rep_left_d;
   logic [XLEN-1:0]   prev_pc_q, prev_pc_d;
   logic              prev_vld_q, prev_vld_d;
   logic [FW-1:0]     k_q, k_d;

   logic [FW-1:0]     k_nxt;
   logic [XLEN-1:0]   exp_sel;
   logic [4:0]        addr_nxt;
   logic [4:0]        addr_first;
   logic [31:0]       cc_nxt;
   logic              pc_same;
   logic              halt_now;

   // halt: self-jump instruction, or pc frozen for HALT_REPEAT repeats in a row
   assign k_nxt      = k_q + FW'(1);
   assign addr_first = chk_addr_flat[4:0];
   assign cc_nxt     = cycle_count_q + 32'd1;
   assign pc_same    = prev_vld_q && (pc == prev_pc_q);
   assign halt_now   = (instruction == HALT_INSN) || (pc_same && (rep_left_q == RP_ONE));

   // select expected value for the current check and address for the next one
   always_comb begin
      exp_sel  = '0;
      addr_nxt = '0;
      for (int i = 0; i < NCHK; i++) begin
         if (k_q == FW'(i))   exp_sel  = chk_exp_flat[i*XLEN +: XLEN];
         if (k_nxt == FW'(i)) addr_nxt = chk_addr_flat[i*5 +: 5];
      end
   end

   // next-state and next-output computation
   always_comb begin
      state_d       = state_q;
      core_rst_d    = core_rst_q;
      dbg_addr_d    = dbg_addr_q;
      busy_d        = busy_q;
      done_d        = done_q;
      pass_d        = pass_q;
      halted_d      = halted_q;
      timeout_d     = timeout_q;
      cycle_count_d = cycle_count_q;
      fail_idx_d    = fail_idx_q;
      rst_cnt_d     = rst_cnt_q;
      rep_left_d    = rep_left_q;
      prev_pc_d     = prev_pc_q;
      prev_vld_d    = prev_vld_q;
      k_d           = k_q;

      unique case (state_q)
         S_IDLE, S_DONE: begin
            if (start) begin
               state_d       = S_RESET;
               core_rst_d    = 1'b1;
               busy_d        = 1'b1;
               done_d        = 1'b0;
               pass_d        = 1'b0;
               halted_d      = 1'b0;
               timeout_d     = 1'b0;
               cycle_count_d = '0;
               fail_idx_d    = NCHK_F;
               rst_cnt_d     = RC_LOAD;
            end
         end
         S_RESET: begin
            if (rst_cnt_q == '0) begin
               state_d    = S_RUN;
               core_rst_d = 1'b0;
               prev_vld_d = 1'b0;
               rep_left_d = RP_LOAD;
            end else begin
               rst_cnt_d = rst_cnt_q - RCW'(1);
            end
         end
         S_RUN: begin
            cycle_count_d = cc_nxt;
            prev_pc_d     = pc;
            prev_vld_d    = 1'b1;
            rep_left_d    = pc_same ? (rep_left_q - RPW'(1)) : RP_LOAD;
            if (halt_now) begin
               state_d    = S_CHECK;
               halted_d   = 1'b1;
               k_d        = '0;
               dbg_addr_d = addr_first;
            end else if (cc_nxt == MAX_C) begin
               state_d    = S_DONE;
               timeout_d  = 1'b1;
               pass_d     = 1'b0;
               fail_idx_d = NCHK_F;
               busy_d     = 1'b0;
               done_d     = 1'b1;
            end
         end
         S_CHECK: begin
            if (dbg_data != exp_sel) begin
               state_d    = S_DONE;
               fail_idx_d = k_q;
               pass_d     = 1'b0;
               busy_d     = 1'b0;
               done_d     = 1'b1;
            end else if (k_q == K_LAST) begin
               state_d = S_DONE;
               pass_d  = 1'b1;
               busy_d  = 1'b0;
               done_d  = 1'b1;
            end else begin
               k_d        = k_nxt;
               dbg_addr_d = addr_nxt;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // state and registered outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= S_IDLE;
         core_rst_q    <= 1'b1;
         dbg_addr_q    <= '0;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
         pass_q        <= 1'b0;
         halted_q      <= 1'b0;
         timeout_q     <= 1'b0;
         cycle_count_q <= '0;
         fail_idx_q    <= NCHK_F;
         rst_cnt_q     <= '0;
         rep_left_q    <= RP_LOAD;
         prev_pc_q     <= '0;
         prev_vld_q    <= 1'b0;
         k_q           <= '0;
      end else begin
         state_q       <= state_d;
         core_rst_q    <= core_rst_d;
         dbg_addr_q    <= dbg_addr_d;
         busy_q        <= busy_d;
         done_q        <= done_d;
         pass_q        <= pass_d;
         halted_q      <= halted_d;
         timeout_q     <= timeout_d;
         cycle_count_q <= cycle_count_d;
         fail_idx_q    <= fail_idx_d;
         rst_cnt_q     <= rst_cnt_d;
         rep_left_q    <= rep_left_d;
         prev_pc_q     <= prev_pc_d;
         prev_vld_q    <= prev_vld_d;
         k_q           <= k_d;
      end
   end

   assign core_rst    = core_rst_q;
   assign dbg_addr    = dbg_addr_q;
   assign busy        = busy_q;
   assign done        = done_q;
   assign pass        = pass_q;
   assign halted      = halted_q;
   assign timeout     = timeout_q;
   assign cycle_count = cycle_count_q;
   assign fail_idx    = fail_idx_q;

endmodule

// File: tb/tb_poliriscv_run_ctrl.sv
// Bench for poliriscv_run_ctrl: a tiny core model (pc stepping through a
// program table, register file behind the debug port) plus a scoreboard of
// expected run results computed from the program when each run is started.
module tb_poliriscv_run_ctrl;

   localparam int XLEN = 32;
   localparam int NCHK = 2;
   localparam int RSTC = 2;
   localparam int MAXC = 20;
   localparam int HREP = 2;
   localparam int FW   = $clog2(NCHK + 1);

   localparam logic [31:0] JAL0 = 32'h0000_006F;
   localparam logic [31:0] BEQ0 = 32'h0000_0063;
   localparam logic [31:0] NOP  = 32'h0000_0013;

   logic                  clk = 1'b0;
   logic                  rst = 1'b1;
   logic                  start = 1'b0;
   logic [NCHK*5-1:0]     chk_addr_flat = '0;
   logic [NCHK*XLEN-1:0]  chk_exp_flat = '0;
   logic [XLEN-1:0]       pc = '0;
   logic [31:0]           instruction;
   logic [XLEN-1:0]       dbg_data;
   logic                  core_rst;
   logic [4:0]            dbg_addr;
   logic                  busy, done, pass, halted, timeout;
   logic [31:0]           cycle_count;
   logic [FW-1:0]         fail_idx;

   logic [31:0]           prog [32];
   logic [XLEN-1:0]       regs [32];
   logic [4:0]            tb_addr [NCHK];
   logic [XLEN-1:0]       tb_exp  [NCHK];

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic        halted;
      logic        timeout;
      logic        pass;
      logic [31:0] fidx;
      logic [31:0] cc;
      int          lat;
   } exp_t;

   exp_t sb [$];

   poliriscv_run_ctrl #(
      .XLEN(XLEN), .NCHK(NCHK), .RST_CYCLES(RSTC),
      .MAX_CYCLES(MAXC), .HALT_REPEAT(HREP)
   ) dut (
      .clk(clk), .rst(rst), .start(start),
      .chk_addr_flat(chk_addr_flat), .chk_exp_flat(chk_exp_flat),
      .pc(pc), .instruction(instruction), .dbg_data(dbg_data),
      .core_rst(core_rst), .dbg_addr(dbg_addr), .busy(busy), .done(done),
      .pass(pass), .halted(halted), .timeout(timeout),
      .cycle_count(cycle_count), .fail_idx(fail_idx)
   );

   always #5 clk = ~clk;

   // core model: self-jump and self-branch freeze pc, anything else steps
   assign instruction = prog[pc[6:2]];
   assign dbg_data    = regs[dbg_addr];
   always @(posedge clk) begin
      if (core_rst) pc <= '0;
      else if (instruction != JAL0 && instruction != BEQ0) pc <= pc + 32'd4;
   end

   task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
      end
   endtask

   task automatic clear_prog();
      for (int i = 0; i < 32; i++) prog[i] = NOP;
   endtask

   task automatic set_checks(input logic [4:0] a0, input logic [31:0] e0,
                             input logic [4:0] a1, input logic [31:0] e1);
      tb_addr[0] = a0; tb_exp[0] = e0;
      tb_addr[1] = a1; tb_exp[1] = e1;
      chk_addr_flat = {a1, a0};
      chk_exp_flat  = {e1, e0};
   endtask

   // expected outcome of a run, derived from program table and register file
   function automatic exp_t model();
      exp_t e;
      int pcw = 0, prev = 0, rep = 0, cyc = MAXC, m = 0;
      bit halt = 0;
      logic [31:0] ins;
      for (int n = 1; n <= MAXC; n++) begin
         ins = prog[pcw % 32];
         if (ins == JAL0) halt = 1;
         if (n > 1 && pcw == prev) rep++; else rep = 0;
         if (rep >= HREP) halt = 1;
         if (halt) begin cyc = n; break; end
         prev = pcw;
         if (ins != JAL0 && ins != BEQ0) pcw++;
      end
      e.halted = halt;
      e.timeout = !halt;
      e.cc = cyc;
      e.fidx = NCHK;
      e.pass = 0;
      if (halt) begin
         e.pass = 1;
         for (int k = 0; k < NCHK; k++) begin
            m = k + 1;
            if (regs[tb_addr[k]] !== tb_exp[k]) begin
               e.fidx = k;
               e.pass = 0;
               break;
            end
         end
         e.lat = RSTC + cyc + m;
      end else begin
         e.lat = RSTC + MAXC;
      end
      return e;
   endfunction

   // one complete run; pulse_at>0 injects a start pulse that must be ignored
   task automatic run(input string tag, input int pulse_at);
      exp_t e;
      int cnt = 0;
      int rst_hi = 0;
      sb.push_back(model());
      @(negedge clk); start = 1'b1;
      @(posedge clk); #1; start = 1'b0;
      chk({tag, "_busy_on_start"}, busy, 1);
      chk({tag, "_flags_cleared"}, {done, halted, timeout, pass}, 0);
      chk({tag, "_cc_cleared"}, cycle_count, 0);
      if (core_rst) rst_hi++;
      while (!done && cnt < 200) begin
         @(posedge clk); #1;
         cnt++;
         if (start) start = 1'b0;
         if (cnt == pulse_at) start = 1'b1;
         if (core_rst && !done) rst_hi++;
      end
      start = 1'b0;
      e = sb.pop_front();
      chk({tag, "_done"}, done, 1);
      chk({tag, "_busy_off"}, busy, 0);
      chk({tag, "_halted"}, halted, e.halted);
      chk({tag, "_timeout"}, timeout, e.timeout);
      chk({tag, "_pass"}, pass, e.pass);
      chk({tag, "_fail_idx"}, fail_idx, e.fidx);
      chk({tag, "_cycle_count"}, cycle_count, e.cc);
      chk({tag, "_latency"}, cnt, e.lat);
      chk({tag, "_core_rst_len"}, rst_hi, RSTC);
      chk({tag, "_core_rst_done"}, core_rst, 0);
   endtask

   initial begin
      clear_prog();
      for (int i = 0; i < 32; i++) regs[i] = 32'(i * 3 + 100);
      regs[0] = '0;
      set_checks(5'd10, 32'd5, 5'd11, 32'd9);

      repeat (3) @(posedge clk);
      #1;
      chk("rst_core_rst", core_rst, 1);
      chk("rst_flags", {busy, done, pass, halted, timeout}, 0);
      chk("rst_cc", cycle_count, 0);
      chk("rst_fail_idx", fail_idx, NCHK);
      chk("rst_dbg_addr", dbg_addr, 0);
      rst = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("idle_core_rst", core_rst, 1);

      // T1: a0=5, x11=9, jal x0,0 at word 3; both checks match
      regs[10] = 32'd5; regs[11] = 32'd9; regs[12] = 32'd3;
      prog[3] = JAL0;
      run("t1", 0);

      // T2: second check fails (x12 is 3, expected 7)
      set_checks(5'd10, 32'd5, 5'd12, 32'd7);
      run("t2", 0);

      // x0 checked like any other register; first check fails
      set_checks(5'd0, 32'd1, 5'd10, 32'd5);
      run("x0_fail", 0);

      // T3: no halt, pc keeps moving -> timeout
      clear_prog();
      set_checks(5'd10, 32'd5, 5'd11, 32'd9);
      run("t3", 0);

      // T6: self-jump first fetched in the very last budget cycle
      prog[19] = JAL0;
      run("t6", 0);

      // halt by pc repeating (branch-to-self)
      clear_prog();
      prog[5] = BEQ0;
      run("rep_halt", 0);

      // T5: start during RUN ignored, then rerun from DONE gives same result
      clear_prog();
      prog[3] = JAL0;
      run("t5a", RSTC + 2);
      run("t5b", 0);

      // T4: rst in RUN cycle 7
      clear_prog();
      @(negedge clk); start = 1'b1;
      @(posedge clk); #1; start = 1'b0;
      repeat (RSTC + 6) @(posedge clk);
      #1;
      chk("t4_cc_before", cycle_count, 6);
      chk("t4_busy_before", busy, 1);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("t4_busy", busy, 0);
      chk("t4_core_rst", core_rst, 1);
      chk("t4_cc", cycle_count, 0);
      chk("t4_flags", {done, pass, halted, timeout}, 0);
      chk("t4_fail_idx", fail_idx, NCHK);

      // fresh run after the mid-run reset
      prog[3] = JAL0;
      run("after_rst", 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
